ps2_command_transmitter: RTL and testbench

//  Host-to-device side of the PS/2 link. Sends one command byte to the keyboard,
//  e.g. 8'hED set-LEDs, 8'hFF reset, 8'hF4 enable scanning.

---
 rtl/ps2_command_transmitter_pkg.sv | 27 ++
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_command_transmitter.sv | 153 +++++++++++++++
 tb/tb_ps2_command_transmitter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_command_transmitter_pkg.sv
// Shared PS/2 definitions: command/response codes, transmitter state encoding
// and the frame parity helper.
package ps2_command_transmitter_pkg;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK_CODE     = 8'hFA;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_INHIBIT    = 4'd1,
    S_REQ        = 4'd2,
    S_WAIT_START = 4'd3,
    S_SHIFT      = 4'd4,
    S_ACK        = 4'd5,
    S_WAIT_IDLE  = 4'd6,
    S_DONE       = 4'd7,
    S_ERR        = 4'd8
  } tx_state_t;

  // PS/2 frames use odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus a one-cycle
// pulse on each synchronised clock falling edge. Shared with the receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;

  // Idle bus level is high, so reset to 1 to avoid a false edge at reset exit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_ff   <= '1;
      dat_ff   <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      dat_ff   <= {dat_ff[0], ps2_dat_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync = clk_ff[1];
  assign dat_sync = dat_ff[1];
  assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_command_transmitter.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts
// out one command byte on device clock falls and checks the device ACK.
module ps2_command_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned XFER_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  import ps2_command_transmitter_pkg::*;

  localparam int unsigned TMAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int unsigned TMAX   = (TMAX_A > XFER_TIMEOUT) ? TMAX_A : XFER_TIMEOUT;
  localparam int unsigned TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);

  tx_state_t     state, state_n;
  logic [TW-1:0] timer;
  logic [8:0]    shreg;
  logic          tx_bit;
  logic [3:0]    bit_cnt;

  logic clk_sync, dat_sync, clk_fall;
  logic load, shift_en, timer_clr;

  ps2_line_sync u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .clk_sync  (clk_sync),
    .dat_sync  (dat_sync),
    .clk_fall  (clk_fall)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Saturating timer shared by the inhibit, start and transfer phases.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              timer <= '0;
    else if (timer_clr)       timer <= '0;
    else if (timer != '1)     timer <= timer + TW'(1);
  end

  // Shifting in ones means the tenth fall naturally presents the stop bit (released line).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg   <= '1;
      tx_bit  <= 1'b1;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= {odd_parity(cmd_data), cmd_data};
      tx_bit  <= 1'b0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      tx_bit  <= shreg[0];
      shreg   <= {1'b1, shreg[8:1]};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_comb begin
    state_n    = state;
    cmd_ready  = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    timer_clr  = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          load      = 1'b1;
          timer_clr = 1'b1;
          state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (timer >= INH_LAST) begin
          timer_clr = 1'b1;
          state_n   = S_REQ;
        end
      end
      S_REQ: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        timer_clr  = 1'b1;
        state_n    = S_WAIT_START;
      end
      S_WAIT_START: begin
        ps2_dat_oe = 1'b1;
        if (clk_fall) begin
          shift_en  = 1'b1;
          timer_clr = 1'b1;
          state_n   = S_SHIFT;
        end else if (timer >= START_LAST) begin
          state_n = S_ERR;
        end
      end
      S_SHIFT: begin
        ps2_dat_oe = ~tx_bit;
        if (timer >= XFER_LAST) begin
          state_n = S_ERR;
        end else if (clk_fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd9) state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (timer >= XFER_LAST)  state_n = S_ERR;
        else if (clk_fall)       state_n = dat_sync ? S_ERR : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (timer >= XFER_LAST)         state_n = S_ERR;
        else if (clk_sync && dat_sync)  state_n = S_DONE;
      end
      S_DONE: begin
        tx_done = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR: begin
        tx_error = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_command_transmitter.sv
// Bench for ps2_command_transmitter with an open-drain bus and a behavioural
// PS/2 device that clocks frames, samples on rising edges and returns ACK.
module tb_ps2_command_transmitter;
  import ps2_command_transmitter_pkg::*;

  localparam int unsigned INH = 500;
  localparam int unsigned STO = 3000;
  localparam int unsigned XTO = 2000;
  localparam int          H   = 40;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       clk_line, dat_line;

  assign clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_command_transmitter #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .XFER_TIMEOUT  (XTO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0, done_cnt = 0, err_cnt = 0, inh_len = 0;
  int   rel_cyc = 0, err_cyc = 0, done_cyc = 0;
  logic clk_oe_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (tx_done)  begin done_cnt++; done_cyc = cyc; end
    if (tx_error) begin err_cnt++;  err_cyc  = cyc; end
    if (ps2_clk_oe && !ps2_dat_oe) inh_len++;
    if (clk_oe_q && !ps2_clk_oe) rel_cyc = cyc;
    clk_oe_q = ps2_clk_oe;
  end

  typedef struct {
    logic [7:0] cmd;
    bit         ack;
    int         exp_done;
    int         exp_err;
  } vec_t;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Device: waits for request-to-send, clocks 11 pulses, samples on rises.
  task automatic dev_xfer(input bit ack, input int abort_at,
                          output logic [10:0] frame, output bit ok);
    int n;
    frame = '0;
    ok    = 1'b0;
    n     = 0;
    while (!(clk_line && !dat_line) && n < 8000) begin tick(); n++; end
    if (n >= 8000) return;
    repeat (20) tick();
    frame[0] = dat_line;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (k == abort_at) begin
        repeat (H/2) tick();
        ok = 1'b1;
        return;
      end
      repeat (H) tick();
      dev_clk_low = 1'b0;
      if (k <= 10) frame[k] = dat_line;
      if (k == 11) dev_dat_low = 1'b0;
      if (k == 10 && ack) begin
        repeat (5) tick();
        dev_dat_low = 1'b1;
        repeat (H - 5) tick();
      end else begin
        repeat (H) tick();
      end
    end
    ok = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 5000) begin tick(); n++; end
    check("idle_reached", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic run_txn(input logic [7:0] cmd, input bit ack,
                         output logic [10:0] frame, output bit ok);
    inh_len = 0;
    fork
      begin
        tick();
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        tick();
        cmd_valid = 1'b0;
      end
      dev_xfer(ack, 0, frame, ok);
    join
    wait_idle();
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    logic [10:0] f;
    bit          ok;
    int          d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    run_txn(v.cmd, v.ack, f, ok);
    check({tag, "_dev_ok"}, {31'd0, ok}, 32'd1);
    check({tag, "_frame"}, {21'd0, f}, {21'd0, ref_frame(v.cmd)});
    check({tag, "_done"}, done_cnt - d0, v.exp_done);
    check({tag, "_error"}, err_cnt - e0, v.exp_err);
    check({tag, "_inhibit_len"}, inh_len, INH);
    check({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_oe_after"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t        tbl[6];
    vec_t        rv;
    logic [10:0] f1, f2;
    bit          ok1, ok2;
    int          n, d0, e0, gap, dlt;

    tbl[0] = '{PS2_CMD_SET_LEDS, 1'b1, 1, 0};
    tbl[1] = '{8'h00,            1'b1, 1, 0};
    tbl[2] = '{PS2_CMD_RESET,    1'b1, 1, 0};
    tbl[3] = '{PS2_CMD_ENABLE,   1'b1, 1, 0};
    tbl[4] = '{PS2_CMD_SET_LEDS, 1'b0, 0, 1};
    tbl[5] = '{PS2_ACK_CODE,     1'b1, 1, 0};

    repeat (3) tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_error", {31'd0, tx_error}, 32'd0);
    resetn = 1'b1;
    repeat (10) tick();
    check("post_rst_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("post_rst_busy", {31'd0, tx_busy}, 32'd0);

    for (int i = 0; i < 6; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      rv.cmd      = 8'($urandom);
      rv.ack      = ($urandom_range(0, 3) != 0);
      rv.exp_done = rv.ack ? 1 : 0;
      rv.exp_err  = rv.ack ? 0 : 1;
      apply_vec(rv, $sformatf("rnd%0d", i));
    end

    // Device never clocks after release.
    d0 = done_cnt;
    e0 = err_cnt;
    tick();
    cmd_valid = 1'b1;
    cmd_data  = PS2_CMD_ENABLE;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (err_cnt == e0 && n < int'(INH + STO + 500)) begin tick(); n++; end
    dlt = err_cyc - rel_cyc;
    check("start_to_error", err_cnt - e0, 1);
    check_rng("start_to_cycles", dlt, int'(STO) - 2, int'(STO) + 2);
    check("start_to_no_done", done_cnt - d0, 0);
    tick();
    check("start_to_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("start_to_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset mid-SHIFT after the fourth device clock fall.
    tick();
    cmd_valid = 1'b1;
    cmd_data  = 8'h00;
    tick();
    cmd_valid = 1'b0;
    dev_xfer(1'b1, 4, f1, ok1);
    check("midrst_dev_ok", {31'd0, ok1}, 32'd1);
    check("midrst_driving", {31'd0, ps2_dat_oe}, 32'd1);
    d0 = done_cnt;
    e0 = err_cnt;
    #2 resetn = 1'b0;
    #1;
    check("midrst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("midrst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    check("midrst_busy", {31'd0, tx_busy}, 32'd0);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (5) tick();
    dev_clk_low = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (50) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_error", err_cnt - e0, 0);
    check("midrst_idle", {31'd0, tx_busy}, 32'd0);

    // Back-to-back commands with cmd_valid held.
    d0  = done_cnt;
    e0  = err_cnt;
    gap = -1;
    fork
      begin
        tick();
        cmd_valid = 1'b1;
        cmd_data  = PS2_CMD_RESET;
        tick();
        cmd_data = PS2_CMD_ENABLE;
        n = 0;
        while (!cmd_ready && n < 6000) begin tick(); n++; end
        gap = cyc - done_cyc;
        tick();
        cmd_valid = 1'b0;
      end
      begin
        dev_xfer(1'b1, 0, f1, ok1);
        dev_xfer(1'b1, 0, f2, ok2);
      end
    join
    wait_idle();
    check("b2b_accept_gap", gap, 1);
    check("b2b_frame1", {21'd0, f1}, {21'd0, ref_frame(PS2_CMD_RESET)});
    check("b2b_frame2", {21'd0, f2}, {21'd0, ref_frame(PS2_CMD_ENABLE)});
    check("b2b_dev_ok", {30'd0, ok1, ok2}, 32'd3);
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_error", err_cnt - e0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
